// File: rtl/eth_sram_pkg.sv
// Shared definitions for the ethernet 2-port SRAM: controller state
// encoding and the elaboration-time parameter legality check.
package eth_sram_pkg;

  // Clear-sweep controller states.
  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_e;

  // True when the latency is 1 or 2 and the word splits into whole lanes.
  function automatic bit params_legal(input int rd_latency,
                                      input int data_width,
                                      input int byte_width);
    return ((rd_latency == 1) || (rd_latency == 2)) &&
           (byte_width > 0) && ((data_width % byte_width) == 0);
  endfunction

endpackage

// File: rtl/eth_sram_2port_array.sv
// Raw 1W/1R storage: per-lane masked write port and a registered read
// port whose output register only updates on an enabled read.
module eth_sram_2port_array #(
  parameter int DATA_WIDTH = 88,
  parameter int BYTE_WIDTH = 8,
  parameter int BE_WIDTH   = DATA_WIDTH / BYTE_WIDTH,
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_a,
  input  logic [DATA_WIDTH-1:0] wr_d,
  input  logic [BE_WIDTH-1:0]   wr_be,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_a,
  output logic [DATA_WIDTH-1:0] rd_q
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  // Masked write: only lanes with their enable set are updated.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < BE_WIDTH; i++) begin
        if (wr_be[i]) begin
          mem[wr_a][i*BYTE_WIDTH +: BYTE_WIDTH] <= wr_d[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  // Read register holds its last value when no read is enabled.
  always_comb begin
    rdata_d = rdata_q;
    if (rd_en) begin
      rdata_d = mem[rd_a];
    end
  end

  // Read register update; cleared by reset so no stale word leaks out.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rd_q = rdata_q;

endmodule

// File: rtl/eth_sram_2port_init.sv
// Ethernet 2-port SRAM wrapper: post-reset clear sweep, byte-enable
// writes, write-first/read-first collision handling, 1- or 2-cycle read
// latency with a one-cycle valid strobe.
//
// Port protocol: a request is presented by driving sram_wr_cen/sram_rd_cen
// low for one cycle and is taken on that rising edge only while init_busy
// is low (requests during the sweep are silently dropped, never queued).
// There is no backpressure. Each accepted read yields exactly one
// sram_rd_vld pulse RD_LATENCY edges later; sram_rd_q holds between pulses.
module eth_sram_2port_init
  import eth_sram_pkg::*;
#(
  parameter int DATA_WIDTH = 88,
  parameter int BYTE_WIDTH = 8,
  parameter int BE_WIDTH   = DATA_WIDTH / BYTE_WIDTH,
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 1024,
  parameter int RD_LATENCY = 1,
  parameter int WR_BYPASS  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sram_wr_cen,
  input  logic [ADDR_WIDTH-1:0] sram_wr_a,
  input  logic [DATA_WIDTH-1:0] sram_wr_d,
  input  logic [BE_WIDTH-1:0]   sram_wr_be,
  input  logic                  sram_rd_cen,
  input  logic [ADDR_WIDTH-1:0] sram_rd_a,
  output logic [DATA_WIDTH-1:0] sram_rd_q,
  output logic                  sram_rd_vld,
  output logic                  init_busy,
  output state_e                dbg_state
);

  // Reject illegal configurations at elaboration.
  generate
    if (!params_legal(RD_LATENCY, DATA_WIDTH, BYTE_WIDTH) ||
        (BE_WIDTH != DATA_WIDTH / BYTE_WIDTH) ||
        (DEPTH > (1 << ADDR_WIDTH)) || (DEPTH < 1)) begin : g_bad_params
      $error("eth_sram_2port_init: illegal parameter combination");
    end
  endgenerate

  localparam logic [ADDR_WIDTH:0]   DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_A  = ADDR_WIDTH'(DEPTH - 1);

  // Controller state
  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  busy_q, busy_d;

  // Array connections
  logic                  arr_wr_en;
  logic [ADDR_WIDTH-1:0] arr_wr_a;
  logic [DATA_WIDTH-1:0] arr_wr_d;
  logic [BE_WIDTH-1:0]   arr_wr_be;
  logic                  arr_rd_en;
  logic [DATA_WIDTH-1:0] arr_rd_q;

  // Request qualification
  logic wr_in_range, rd_in_range, user_wr, rd_acc;

  // Read bookkeeping captured alongside the array read (stage 0)
  logic                  vld0_q, vld0_d;
  logic                  oor0_q, oor0_d;
  logic                  hit0_q, hit0_d;
  logic [DATA_WIDTH-1:0] byp_d0_q, byp_d0_d;
  logic [BE_WIDTH-1:0]   byp_be0_q, byp_be0_d;

  // Stage 1 output register
  logic [DATA_WIDTH-1:0] merged;
  logic [DATA_WIDTH-1:0] q1_q, q1_d;
  logic                  vld1_q, vld1_d;

  assign wr_in_range = ({1'b0, sram_wr_a} < DEPTH_W);
  assign rd_in_range = ({1'b0, sram_rd_a} < DEPTH_W);
  assign user_wr     = (state_q == ST_READY) && !sram_wr_cen && wr_in_range;
  assign rd_acc      = !rst && (state_q == ST_READY) && !sram_rd_cen;

  // Next-state logic: sweep one word per cycle, then park in READY.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    case (state_q)
      ST_INIT: begin
        busy_d = 1'b1;
        if (cnt_q == LAST_A) begin
          state_d = ST_READY;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_WIDTH'(1);
        end
      end
      ST_READY: begin
        busy_d = 1'b0;
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
        busy_d  = 1'b1;
      end
    endcase
  end

  // Controller registers; reset restarts the sweep from address 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  // Write mux: the sweep owns the write port until READY.
  always_comb begin
    arr_wr_en = 1'b0;
    arr_wr_a  = sram_wr_a;
    arr_wr_d  = sram_wr_d;
    arr_wr_be = sram_wr_be;
    if (!rst) begin
      if (state_q == ST_INIT) begin
        arr_wr_en = 1'b1;
        arr_wr_a  = cnt_q;
        arr_wr_d  = '0;
        arr_wr_be = '1;
      end else if (user_wr) begin
        arr_wr_en = 1'b1;
      end
    end
  end

  // Out-of-range reads skip the array and are forced to zero later.
  assign arr_rd_en = rd_acc && rd_in_range;

  eth_sram_2port_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .BYTE_WIDTH (BYTE_WIDTH),
    .BE_WIDTH   (BE_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .wr_en (arr_wr_en),
    .wr_a  (arr_wr_a),
    .wr_d  (arr_wr_d),
    .wr_be (arr_wr_be),
    .rd_en (arr_rd_en),
    .rd_a  (sram_rd_a),
    .rd_q  (arr_rd_q)
  );

  // Capture the read's context; the array itself returns the pre-write
  // word on a collision, so write-first mode keeps the write for merging.
  always_comb begin
    vld0_d    = rd_acc;
    oor0_d    = oor0_q;
    hit0_d    = hit0_q;
    byp_d0_d  = byp_d0_q;
    byp_be0_d = byp_be0_q;
    if (rd_acc) begin
      oor0_d    = !rd_in_range;
      hit0_d    = (WR_BYPASS != 0) && !sram_wr_cen && rd_in_range &&
                  (sram_wr_a == sram_rd_a);
      byp_d0_d  = sram_wr_d;
      byp_be0_d = sram_wr_be;
    end
  end

  // Stage 0 context registers; reset drops any in-flight read.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld0_q    <= 1'b0;
      oor0_q    <= 1'b0;
      hit0_q    <= 1'b0;
      byp_d0_q  <= '0;
      byp_be0_q <= '0;
    end else begin
      vld0_q    <= vld0_d;
      oor0_q    <= oor0_d;
      hit0_q    <= hit0_d;
      byp_d0_q  <= byp_d0_d;
      byp_be0_q <= byp_be0_d;
    end
  end

  // Lane merge for write-first collisions, then the stage 1 register.
  always_comb begin
    for (int i = 0; i < BE_WIDTH; i++) begin
      merged[i*BYTE_WIDTH +: BYTE_WIDTH] = (hit0_q && byp_be0_q[i]) ?
        byp_d0_q[i*BYTE_WIDTH +: BYTE_WIDTH] : arr_rd_q[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
    q1_d   = q1_q;
    vld1_d = vld0_q;
    if (vld0_q) begin
      q1_d = oor0_q ? '0 : merged;
    end
  end

  // Stage 1 output register: holds data between reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      q1_q   <= '0;
      vld1_q <= 1'b0;
    end else begin
      q1_q   <= q1_d;
      vld1_q <= vld1_d;
    end
  end

  generate
    if (RD_LATENCY == 2) begin : g_lat2
      logic [DATA_WIDTH-1:0] q2_q, q2_d;
      logic                  vld2_q, vld2_d;

      // Stage 2 copies the already-resolved stage 1 word.
      always_comb begin
        q2_d   = q2_q;
        vld2_d = vld1_q;
        if (vld1_q) begin
          q2_d = q1_q;
        end
      end

      // Stage 2 register.
      always_ff @(posedge clk) begin
        if (rst) begin
          q2_q   <= '0;
          vld2_q <= 1'b0;
        end else begin
          q2_q   <= q2_d;
          vld2_q <= vld2_d;
        end
      end

      assign sram_rd_q   = q2_q;
      assign sram_rd_vld = vld2_q;
    end else begin : g_lat1
      assign sram_rd_q   = q1_q;
      assign sram_rd_vld = vld1_q;
    end
  endgenerate

  assign init_busy = busy_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_eth_sram_2port_init.sv
// Bench for eth_sram_2port_init: two instances share one stimulus stream,
// A = defaults (1024 words, latency 1, write-first), B = 1000 words,
// latency 2, read-first. A word-array reference model predicts each read.
module tb_eth_sram_2port_init;
  import eth_sram_pkg::*;

  localparam int DW    = 88;
  localparam int AW    = 10;
  localparam int BEW   = 11;
  localparam int DEP_A = 1024;
  localparam int DEP_B = 1000;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Shared stimulus
  logic          wr_cen, rd_cen;
  logic [AW-1:0] wr_a, rd_a;
  logic [DW-1:0] wr_d;
  logic [BEW-1:0] wr_be;

  // Per-instance outputs
  logic [DW-1:0] q_a, q_b;
  logic          vld_a, vld_b, busy_a, busy_b;
  state_e        st_a, st_b;

  eth_sram_2port_init #(
    .DATA_WIDTH(DW), .BYTE_WIDTH(8), .ADDR_WIDTH(AW), .DEPTH(DEP_A),
    .RD_LATENCY(1), .WR_BYPASS(1)
  ) dut_a (
    .clk(clk), .rst(rst), .sram_wr_cen(wr_cen), .sram_wr_a(wr_a),
    .sram_wr_d(wr_d), .sram_wr_be(wr_be), .sram_rd_cen(rd_cen),
    .sram_rd_a(rd_a), .sram_rd_q(q_a), .sram_rd_vld(vld_a),
    .init_busy(busy_a), .dbg_state(st_a)
  );

  eth_sram_2port_init #(
    .DATA_WIDTH(DW), .BYTE_WIDTH(8), .ADDR_WIDTH(AW), .DEPTH(DEP_B),
    .RD_LATENCY(2), .WR_BYPASS(0)
  ) dut_b (
    .clk(clk), .rst(rst), .sram_wr_cen(wr_cen), .sram_wr_a(wr_a),
    .sram_wr_d(wr_d), .sram_wr_be(wr_be), .sram_rd_cen(rd_cen),
    .sram_rd_a(rd_a), .sram_rd_q(q_b), .sram_rd_vld(vld_b),
    .init_busy(busy_b), .dbg_state(st_b)
  );

  // Reference model and scoreboard
  int            n_chk = 0;
  int            n_fail = 0;
  bit            model_ready = 1'b0;
  logic [DW-1:0] mem_a [DEP_A];
  logic [DW-1:0] mem_b [DEP_B];
  logic [DW-1:0] exp_qa[$], exp_qb[$];
  int            exp_ta[$], exp_tb[$];
  logic [DW-1:0] last_a = '0;
  logic [DW-1:0] last_b = '0;

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old,
                                          input logic [DW-1:0] d,
                                          input logic [BEW-1:0] be);
    logic [DW-1:0] r;
    r = old;
    for (int i = 0; i < BEW; i++) if (be[i]) r[i*8 +: 8] = d[i*8 +: 8];
    return r;
  endfunction

  task automatic check(input string name, input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h required=%h", name, got, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < DEP_A; i++) mem_a[i] = '0;
    for (int i = 0; i < DEP_B; i++) mem_b[i] = '0;
  endtask

  // Driver: present one cycle of requests, predict, then cross the edge.
  task automatic drive(input bit wr, input logic [AW-1:0] wa,
                       input logic [DW-1:0] wd, input logic [BEW-1:0] be,
                       input bit rd, input logic [AW-1:0] ra);
    logic [DW-1:0] va, vb;
    wr_cen = !wr; wr_a = wa; wr_d = wd; wr_be = be;
    rd_cen = !rd; rd_a = ra;
    if (model_ready) begin
      if (rd) begin
        va = mem_a[ra];
        if (wr && (wa == ra)) va = merge(va, wd, be);
        vb = '0;
        if (int'(ra) < DEP_B) vb = mem_b[ra];
        exp_qa.push_back(va); exp_ta.push_back(cyc + 2);
        exp_qb.push_back(vb); exp_tb.push_back(cyc + 3);
      end
      if (wr) begin
        mem_a[wa] = merge(mem_a[wa], wd, be);
        if (int'(wa) < DEP_B) mem_b[wa] = merge(mem_b[wa], wd, be);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, '0, 1'b0, '0);
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 9) < 7) return AW'($urandom_range(0, 15));
    return AW'($urandom_range(990, 1023));
  endfunction

  task automatic rand_op();
    logic [AW-1:0] wa, ra;
    wa = rand_addr();
    ra = ($urandom_range(0, 9) < 3) ? wa : rand_addr();
    drive($urandom_range(0, 9) < 7, wa, DW'({$urandom(), $urandom(), $urandom()}),
          BEW'($urandom()), $urandom_range(0, 9) < 7, ra);
  endtask

  // Release reset, throw dropped traffic at the sweep, time init_busy.
  task automatic release_and_sweep();
    int  rel;
    bit  done_a, done_b;
    model_ready = 1'b0;
    clear_model();
    rst = 1'b0;
    rel = cyc;
    done_a = 1'b0; done_b = 1'b0;
    for (int k = 1; k <= 1100 && !(done_a && done_b); k++) begin
      if (k <= 60) rand_op(); else idle();
      if (!done_a && !busy_a) begin
        done_a = 1'b1;
        check("a_busy_len", DW'(cyc - rel), DW'(DEP_A));
        check("a_state_ready", DW'(st_a), DW'(ST_READY));
      end
      if (!done_b && !busy_b) begin
        done_b = 1'b1;
        check("b_busy_len", DW'(cyc - rel), DW'(DEP_B));
        check("b_state_ready", DW'(st_b), DW'(ST_READY));
      end
    end
    if (!done_a) check("a_busy_timeout", DW'(busy_a), '0);
    if (!done_b) check("b_busy_timeout", DW'(busy_b), '0);
    model_ready = 1'b1;
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && (exp_qa.size() > 0 || exp_qb.size() > 0); k++) idle();
    check("a_drain_left", DW'(exp_qa.size()), '0);
    check("b_drain_left", DW'(exp_qb.size()), '0);
  endtask

  // Monitor A: pop on every valid, otherwise q must hold.
  always @(negedge clk) begin
    logic [DW-1:0] ed;
    int            et;
    if (vld_a) begin
      n_chk++;
      if (exp_qa.size() == 0) begin
        n_fail++;
        $display("FAIL a_unexpected_vld cyc=%0d got q=%h required no vld", cyc, q_a);
      end else begin
        ed = exp_qa.pop_front(); et = exp_ta.pop_front();
        if (q_a !== ed || cyc != et) begin
          n_fail++;
          $display("FAIL a_read got q=%h at cyc %0d required q=%h at cyc %0d", q_a, cyc, ed, et);
        end
        last_a = ed;
      end
    end else if (rst) begin
      last_a = '0;
    end else begin
      n_chk++;
      if (q_a !== last_a) begin
        n_fail++;
        $display("FAIL a_hold got=%h required=%h", q_a, last_a);
      end
    end
    if (exp_ta.size() > 0 && exp_ta[0] < cyc) begin
      n_chk++; n_fail++;
      $display("FAIL a_missing_vld got none at cyc %0d required q=%h", exp_ta[0], exp_qa[0]);
      void'(exp_qa.pop_front()); void'(exp_ta.pop_front());
    end
  end

  // Monitor B: same rules for the latency-2 instance.
  always @(negedge clk) begin
    logic [DW-1:0] ed;
    int            et;
    if (vld_b) begin
      n_chk++;
      if (exp_qb.size() == 0) begin
        n_fail++;
        $display("FAIL b_unexpected_vld cyc=%0d got q=%h required no vld", cyc, q_b);
      end else begin
        ed = exp_qb.pop_front(); et = exp_tb.pop_front();
        if (q_b !== ed || cyc != et) begin
          n_fail++;
          $display("FAIL b_read got q=%h at cyc %0d required q=%h at cyc %0d", q_b, cyc, ed, et);
        end
        last_b = ed;
      end
    end else if (rst) begin
      last_b = '0;
    end else begin
      n_chk++;
      if (q_b !== last_b) begin
        n_fail++;
        $display("FAIL b_hold got=%h required=%h", q_b, last_b);
      end
    end
    if (exp_tb.size() > 0 && exp_tb[0] < cyc) begin
      n_chk++; n_fail++;
      $display("FAIL b_missing_vld got none at cyc %0d required q=%h", exp_tb[0], exp_qb[0]);
      void'(exp_qb.pop_front()); void'(exp_tb.pop_front());
    end
  end

  // Main sequence
  initial begin
    logic [DW-1:0] p55, paa;
    p55 = {11{8'h55}};
    paa = {11{8'hAA}};
    rst = 1'b1;
    wr_cen = 1'b1; rd_cen = 1'b1; wr_a = '0; rd_a = '0; wr_d = '0; wr_be = '0;
    repeat (3) @(posedge clk);
    #1;
    check("a_reset_busy", DW'(busy_a), DW'(1));
    check("b_reset_busy", DW'(busy_b), DW'(1));
    check("a_reset_q", q_a, '0);
    check("b_reset_vld", DW'(vld_b), '0);

    release_and_sweep();

    // Post-sweep contents
    drive(1'b0, '0, '0, '0, 1'b1, AW'(0));
    drive(1'b0, '0, '0, '0, 1'b1, AW'(511));
    drive(1'b0, '0, '0, '0, 1'b1, AW'(1023));
    // Byte-enable partial write
    drive(1'b1, AW'(5), p55, '1, 1'b0, '0);
    drive(1'b1, AW'(5), paa, BEW'(1), 1'b0, '0);
    drive(1'b0, '0, '0, '0, 1'b1, AW'(5));
    // Collision
    drive(1'b1, AW'(7), DW'(9), '1, 1'b0, '0);
    drive(1'b1, AW'(7), DW'(16'h1234), '1, 1'b1, AW'(7));
    // Back-to-back reads
    drive(1'b1, AW'(1), DW'(11), '1, 1'b0, '0);
    drive(1'b1, AW'(2), DW'(22), '1, 1'b0, '0);
    drive(1'b1, AW'(3), DW'(33), '1, 1'b0, '0);
    drive(1'b0, '0, '0, '0, 1'b1, AW'(1));
    drive(1'b0, '0, '0, '0, 1'b1, AW'(2));
    drive(1'b0, '0, '0, '0, 1'b1, AW'(3));
    // Depth boundary
    drive(1'b1, AW'(999), DW'(32'hCAFE_0999), '1, 1'b0, '0);
    drive(1'b1, AW'(1010), DW'(32'hDEAD_1010), '1, 1'b0, '0);
    drive(1'b0, '0, '0, '0, 1'b1, AW'(1010));
    drive(1'b0, '0, '0, '0, 1'b1, AW'(999));
    drain();

    // Random traffic
    for (int i = 0; i < 1500; i++) rand_op();
    drain();

    // Read in flight when reset hits: must never produce a strobe.
    model_ready = 1'b0;
    drive(1'b0, '0, '0, '0, 1'b1, AW'(3));
    rst = 1'b1;
    idle(); idle();
    check("a_midread_q", q_a, '0);
    check("b_midread_q", q_b, '0);
    // Reset in the middle of a sweep restarts it.
    rst = 1'b0;
    repeat (300) idle();
    rst = 1'b1;
    idle(); idle();
    release_and_sweep();

    // Everything written earlier must now read back as zero.
    for (int i = 0; i < 200; i++) drive(1'b0, '0, '0, '0, 1'b1, rand_addr());
    drive(1'b0, '0, '0, '0, 1'b1, AW'(511));
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
